// File: rtl/seq_bit_serializer_pkg.sv
// seq_bit_serializer_pkg: shared state encoding and parameter defaults
// for the word-to-bit serializer, its 1010 detector top and benches.
package seq_bit_serializer_pkg;

    localparam int   DEF_WIDTH     = 8;
    localparam int   DEF_MSB_FIRST = 1;
    localparam logic DEF_IDLE_BIT  = 1'b0;
    localparam int   DEF_CNT_W     = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/ser_hold_buf.sv
// ser_hold_buf: one-word holding register with valid/ready intake.
// Ports: clk, reset, s_data/s_valid/s_ready (intake), shift_free (shifter
// can take a word this edge), hold_full, hold_data, load (word moves out).
module ser_hold_buf
    import seq_bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             shift_free,
    output logic             hold_full,
    output logic [WIDTH-1:0] hold_data,
    output logic             load
);

    assign s_ready = !hold_full && !reset;
    assign load    = hold_full && shift_free;

    // Accept requires !hold_full and load requires hold_full, so the two
    // never act on the register in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= 1'b0;
        end else if (s_valid && s_ready) begin
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (s_valid && s_ready) begin
            hold_data <= s_data;
        end
    end

endmodule

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel words in (valid/ready), one bit per clock
// out on dout. Ports: clk, reset, s_data/s_valid/s_ready, dout,
// dout_valid, word_start, busy, words_sent (wraps), gap_cnt (saturates).
module seq_bit_serializer
    import seq_bit_serializer_pkg::*;
#(
    parameter int   WIDTH     = DEF_WIDTH,
    parameter int   MSB_FIRST = DEF_MSB_FIRST,
    parameter logic IDLE_BIT  = DEF_IDLE_BIT,
    parameter int   CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_start,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent,
    output logic [CNT_W-1:0] gap_cnt
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_t       st, st_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             load;
    logic             last;
    logic             shift_free;
    logic             ws_inc;
    logic             gap_inc;

    assign last       = (st == SHIFT) && (bit_cnt == LAST);
    // The shifter can take the next word on the edge that retires the
    // last bit, which keeps back-to-back words contiguous.
    assign shift_free = (st == IDLE) || last;

    ser_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .shift_free(shift_free),
        .hold_full (hold_full),
        .hold_data (hold_data),
        .load      (load)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            words_sent <= '0;
            gap_cnt    <= '0;
        end else begin
            st      <= st_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            if (ws_inc) begin
                words_sent <= words_sent + 1'b1;
            end
            if (gap_inc && (gap_cnt != '1)) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        st_nxt      = st;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        ws_inc      = 1'b0;
        gap_inc     = 1'b0;
        if (load) begin
            st_nxt      = SHIFT;
            shreg_nxt   = hold_data;
            bit_cnt_nxt = '0;
            ws_inc      = 1'b1;
        end else begin
            unique case (st)
                IDLE: begin
                    st_nxt = IDLE;
                end
                SHIFT: begin
                    if (last) begin
                        st_nxt  = IDLE;
                        gap_inc = 1'b1;
                    end else begin
                        if (MSB_FIRST != 0) begin
                            shreg_nxt = shreg << 1;
                        end else begin
                            shreg_nxt = shreg >> 1;
                        end
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
                default: begin
                    st_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dout       = IDLE_BIT;
        dout_valid = 1'b0;
        if (st == SHIFT) begin
            dout       = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
            dout_valid = 1'b1;
        end
    end

    assign word_start = (st == SHIFT) && (bit_cnt == '0);
    assign busy       = (st == SHIFT) || hold_full;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: directed vectors for three serializer builds
// (MSB first, LSB first, 2-bit counters) plus a 1010 detector model.
module tb_seq_bit_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;

    logic        a_ready, a_dout, a_dv, a_ws, a_busy;
    logic [15:0] a_words, a_gaps;
    logic        b_ready, b_dout, b_dv, b_ws, b_busy;
    logic [15:0] b_words, b_gaps;
    logic        c_ready, c_dout, c_dv, c_ws, c_busy;
    logic [1:0]  c_words, c_gaps;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_words = 0;
    int exp_gaps = 0;

    always #5 clk = ~clk;

    seq_bit_serializer #(
        .WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0), .CNT_W(16)
    ) dut_a (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_ready(a_ready), .dout(a_dout), .dout_valid(a_dv),
        .word_start(a_ws), .busy(a_busy), .words_sent(a_words),
        .gap_cnt(a_gaps)
    );

    seq_bit_serializer #(
        .WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b0), .CNT_W(16)
    ) dut_b (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_ready(b_ready), .dout(b_dout), .dout_valid(b_dv),
        .word_start(b_ws), .busy(b_busy), .words_sent(b_words),
        .gap_cnt(b_gaps)
    );

    seq_bit_serializer #(
        .WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0), .CNT_W(2)
    ) dut_c (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_ready(c_ready), .dout(c_dout), .dout_valid(c_dv),
        .word_start(c_ws), .busy(c_busy), .words_sent(c_words),
        .gap_cnt(c_gaps)
    );

    // Overlapping Moore 1010 detector fed by dut_a
    logic [2:0] det_st;
    logic       y;
    assign y = (det_st == 3'd4);

    always_ff @(posedge clk) begin
        if (reset) begin
            det_st <= 3'd0;
        end else begin
            case (det_st)
                3'd0:    det_st <= a_dout ? 3'd1 : 3'd0;
                3'd1:    det_st <= a_dout ? 3'd1 : 3'd2;
                3'd2:    det_st <= a_dout ? 3'd3 : 3'd0;
                3'd3:    det_st <= a_dout ? 3'd1 : 3'd4;
                default: det_st <= a_dout ? 3'd3 : 3'd0;
            endcase
        end
    end

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] msb;
        logic [7:0] lsb;
    } vec_t;

    vec_t tbl [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_cnt(input string nm);
        int cw;
        int cg;
        cw = exp_words % 4;
        cg = (exp_gaps > 3) ? 3 : exp_gaps;
        chk({nm, " a_words"}, 32'(a_words), 32'(exp_words));
        chk({nm, " a_gaps"}, 32'(a_gaps), 32'(exp_gaps));
        chk({nm, " c_words"}, 32'(c_words), 32'(cw));
        chk({nm, " c_gaps"}, 32'(c_gaps), 32'(cg));
    endtask

    task automatic b2b(input logic [7:0] w1, input logic [7:0] w2,
                       input logic chk_y);
        logic [15:0] seq;
        bit          hi;
        seq = {w1, w2};
        s_valid = 1'b1;
        s_data  = w1;
        tick();
        chk("b2b ready0", 32'(a_ready), 0);
        s_data = w2;
        tick();
        for (int k = 0; k < 16; k++) begin
            hi = (k == 0) || (k == 8);
            chk($sformatf("b2b a_dout k%0d", k), 32'(a_dout),
                32'(seq[15-k]));
            chk($sformatf("b2b c_dout k%0d", k), 32'(c_dout),
                32'(seq[15-k]));
            chk($sformatf("b2b dv k%0d", k), 32'(a_dv), 1);
            chk($sformatf("b2b ws k%0d", k), 32'(a_ws), 32'(hi));
            chk($sformatf("b2b ready k%0d", k), 32'(a_ready),
                32'((k == 0) || (k >= 8)));
            chk($sformatf("b2b busy k%0d", k), 32'(a_busy), 1);
            if (chk_y) begin
                chk($sformatf("det y k%0d", k), 32'(y), 32'(k == 8));
            end
            tick();
            if (k == 0) begin
                s_valid = 1'b0;
            end
        end
        exp_words += 2;
        exp_gaps  += 1;
        chk("b2b end dv", 32'(a_dv), 0);
        chk("b2b end dout", 32'(a_dout), 0);
        chk_cnt("b2b");
    endtask

    initial begin
        tbl[0] = '{data: 8'hA5, msb: 8'hA5, lsb: 8'hA5};
        tbl[1] = '{data: 8'h01, msb: 8'h01, lsb: 8'h80};
        tbl[2] = '{data: 8'h3C, msb: 8'h3C, lsb: 8'h3C};
        tbl[3] = '{data: 8'h0B, msb: 8'h0B, lsb: 8'hD0};
        tbl[4] = '{data: 8'hE1, msb: 8'hE1, lsb: 8'h87};

        // Reset state
        tick();
        tick();
        chk("rst ready", 32'(a_ready), 0);
        chk("rst dout", 32'(a_dout), 0);
        chk("rst dv", 32'(a_dv), 0);
        chk("rst ws", 32'(a_ws), 0);
        chk("rst busy", 32'(a_busy), 0);
        reset = 1'b0;
        tick();
        chk("post rst ready", 32'(a_ready), 1);
        chk_cnt("rst");

        // Single words, one burst each, counters tracked per burst
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = tbl[i].data;
            tick();
            chk($sformatf("v%0d ready", i), 32'(a_ready), 0);
            chk($sformatf("v%0d busy", i), 32'(a_busy), 1);
            chk($sformatf("v%0d dv0", i), 32'(a_dv), 0);
            s_valid = 1'b0;
            tick();
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("v%0d a_dout k%0d", i, k), 32'(a_dout),
                    32'(tbl[i].msb[7-k]));
                chk($sformatf("v%0d b_dout k%0d", i, k), 32'(b_dout),
                    32'(tbl[i].lsb[7-k]));
                chk($sformatf("v%0d c_dout k%0d", i, k), 32'(c_dout),
                    32'(tbl[i].msb[7-k]));
                chk($sformatf("v%0d dv k%0d", i, k), 32'(a_dv), 1);
                chk($sformatf("v%0d b_dv k%0d", i, k), 32'(b_dv), 1);
                chk($sformatf("v%0d ws k%0d", i, k), 32'(a_ws),
                    32'(k == 0));
                tick();
            end
            exp_words++;
            exp_gaps++;
            chk($sformatf("v%0d end dv", i), 32'(a_dv), 0);
            chk($sformatf("v%0d end busy", i), 32'(a_busy), 0);
            chk($sformatf("v%0d end dout", i), 32'(a_dout), 0);
            chk_cnt($sformatf("v%0d", i));
        end

        // Back-to-back words with s_valid held
        b2b(8'hA0, 8'h5A, 1'b0);

        // Reset mid-word with a second word held
        s_valid = 1'b1;
        s_data  = 8'hFF;
        tick();
        s_data = 8'h33;
        tick();
        tick();
        s_valid = 1'b0;
        chk("mid hold busy", 32'(a_busy), 1);
        chk("mid hold ready", 32'(a_ready), 0);
        tick();
        chk("mid bit3 dout", 32'(a_dout), 1);
        reset = 1'b1;
        tick();
        exp_words = 0;
        exp_gaps  = 0;
        chk("mid rst dout", 32'(a_dout), 0);
        chk("mid rst dv", 32'(a_dv), 0);
        chk("mid rst busy", 32'(a_busy), 0);
        chk("mid rst b_busy", 32'(b_busy), 0);
        chk("mid rst ready", 32'(a_ready), 0);
        chk_cnt("mid rst");
        reset = 1'b0;
        tick();
        chk("mid post ready", 32'(a_ready), 1);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("mid no resume k%0d", k), 32'(a_dv | a_busy), 0);
            tick();
        end

        // Detector integration: 0x0A then 0x05, then idle zeros
        b2b(8'h0A, 8'h05, 1'b1);
        chk("det trail y0", 32'(y), 0);
        tick();
        chk("det trail y1", 32'(y), 1);
        tick();
        chk("det trail y2", 32'(y), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
